// File: rtl/serial_tx_arbiter_pkg.sv
// serial_tx_arbiter_pkg: shared state encoding and timing constants for the UART sender arbiter.
package serial_tx_arbiter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, BUSY = 2'd2} state_t;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int CLK_FREQUENCY = 100_000_000;
    localparam int BAUD_RATE = 9600;
    // Two whole bit periods; integer division first so the result is 20832.
    localparam int START_TIMEOUT_DEF = 2 * (CLK_FREQUENCY / BAUD_RATE);
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1) % n;
    endfunction
endpackage

// File: rtl/serial_tx_arbiter_if.sv
// serial_tx_arbiter_if: requester bus plus sender handshake shared by the arbiter and its users.
interface serial_tx_arbiter_if import serial_tx_arbiter_pkg::*; #(
    parameter int N_REQ = 4,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic [N_REQ-1:0] req;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0] ack;
    logic [N_REQ-1:0] grant;
    logic [DATA_WIDTH-1:0] tx_data;
    logic tx_en;
    logic tx_status;
    logic busy;
    logic err;
    modport master (input req, req_data, tx_status, output ack, grant, tx_data, tx_en, busy, err);
    modport slave (output req, req_data, tx_status, input ack, grant, tx_data, tx_en, busy, err);
endinterface

// File: rtl/serial_tx_arbiter_rr_picker.sv
// serial_tx_arbiter_rr_picker: combinational round-robin selector starting the search at ptr_i.
module serial_tx_arbiter_rr_picker import serial_tx_arbiter_pkg::*; #(
    parameter int N_REQ = 4,
    parameter int PW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [N_REQ-1:0] onehot_o,
    output logic [PW-1:0]    idx_o,
    output logic             valid_o
);
    // Scan from the farthest offset down so the closest set bit to ptr_i wins last.
    always_comb begin
        onehot_o = '0;
        idx_o = '0;
        valid_o = |req_i;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_i) + i) % N_REQ]) begin
                idx_o = PW'((int'(ptr_i) + i) % N_REQ);
                onehot_o = '0;
                onehot_o[(int'(ptr_i) + i) % N_REQ] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin sharing of one UART sender with start timeout and per-frame ack.
module serial_tx_arbiter import serial_tx_arbiter_pkg::*; #(
    parameter int N_REQ = 4,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
    input logic clk,
    input logic rst_n,
    serial_tx_arbiter_if.master bus
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(START_TIMEOUT);
    state_t state_q;
    logic [N_REQ-1:0] ack_q, grant_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic tx_en_q, busy_q, err_q;
    logic [PW-1:0] ptr_q, win_q;
    logic [CW-1:0] cnt_q;
    logic [N_REQ-1:0] pick_onehot;
    logic [PW-1:0] pick_idx;
    logic pick_valid;

    serial_tx_arbiter_rr_picker #(.N_REQ(N_REQ), .PW(PW)) u_picker (
        .req_i(bus.req),
        .ptr_i(ptr_q),
        .onehot_o(pick_onehot),
        .idx_o(pick_idx),
        .valid_o(pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_q <= '0;
            grant_q <= '0;
            tx_data_q <= '0;
            tx_en_q <= 1'b0;
            busy_q <= 1'b0;
            err_q <= 1'b0;
            ptr_q <= '0;
            win_q <= '0;
            cnt_q <= '0;
        end else begin
            ack_q <= '0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.tx_status && pick_valid) begin
                        grant_q <= pick_onehot;
                        tx_data_q <= bus.req_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                        tx_en_q <= 1'b1;
                        busy_q <= 1'b1;
                        win_q <= pick_idx;
                        cnt_q <= '0;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q <= cnt_q + 1'b1;
                    // A start seen on the final cycle still counts; it outranks the timeout.
                    if (!bus.tx_status) begin
                        tx_en_q <= 1'b0;
                        state_q <= BUSY;
                    end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
                        tx_en_q <= 1'b0;
                        grant_q <= '0;
                        busy_q <= 1'b0;
                        err_q <= 1'b1;
                        ptr_q <= PW'(next_idx(int'(win_q), N_REQ));
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    if (bus.tx_status) begin
                        ack_q <= grant_q;
                        grant_q <= '0;
                        busy_q <= 1'b0;
                        ptr_q <= PW'(next_idx(int'(win_q), N_REQ));
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_en_q <= 1'b0;
                    grant_q <= '0;
                    busy_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack = ack_q;
    assign bus.grant = grant_q;
    assign bus.tx_data = tx_data_q;
    assign bus.tx_en = tx_en_q;
    assign bus.busy = busy_q;
    assign bus.err = err_q;
endmodule
